booth16_mul_ctrl: RTL and testbench
===================================

# booth16_mul_ctrl

Sequencing controller for the radix-16 Booth-encoded multiplier datapath. It accepts a multiply request through a ready/valid handshake and drives the load enables of the multiplicand and multiplier registers. It then runs the hard-multiple precompute phase, steps one Booth digit per cycle through the partial-product accumulator, and holds the result valid until the consumer takes it. It carries no operand or result data; it only times the datapath.

## Interface
- WIDTH, mul_pkg::WIDTH (16): operand width; must be a multiple of 4.
- PRE_CYCLES, 2: cycles for precomputing 3x/5x/7x multiples; legal range 1..7.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  controller can accept a request.
- in_signed  in  1  operands are signed; captured on acceptance.
- abort  in  1  cancel the current operation.
- load_mcand  out  1  load enable for the multiplicand register.
- load_mplier  out  1  load enable for the multiplier register.
- acc_clr  out  1  clear the accumulator.
- precomp_en  out  1  enable the hard-multiple generator.
- acc_en  out  1  add the selected partial product to the accumulator.
- shift_en  out  1  shift the multiplier register right by 4.
- digit_idx  out  $clog2(N_DIGITS)  index of the current Booth digit.
- sign_mode  out  1  registered in_signed for the datapath.
- out_valid  out  1  result in the accumulator is final.
- out_ready  in  1  consumer accepts the result.

## Operation
- N_DIGITS = WIDTH/4.
- States:
  - IDLE → LOAD on in_valid & in_ready.
  - LOAD → PRECOMP after 1 cycle.
  - PRECOMP → ITER after PRE_CYCLES cycles.
  - ITER → DONE after N_DIGITS cycles.
  - DONE → IDLE on out_ready.
- Outputs are Moore-decoded from state and counters:
  - IDLE: in_ready=1.
  - LOAD: load_mcand=1, load_mplier=1, acc_clr=1.
  - PRECOMP: precomp_en=1.
  - ITER: acc_en=1, shift_en=1; digit_idx counts 0..N_DIGITS-1.
  - DONE: out_valid=1.
- All other outputs are 0 in each state. digit_idx is 0 outside ITER.
- sign_mode loads from in_signed on acceptance and holds until the next acceptance.
- abort from any non-IDLE state: next state is IDLE and counters clear. abort has priority over every other transition. abort in IDLE has no effect.
- in_valid outside IDLE is ignored. There is no queueing; the requester must hold in_valid until in_ready.
- DONE with out_ready=0: out_valid stays high and all enables stay low. The accumulator must not change.
- DONE & out_ready: IDLE in the next cycle. A new request is accepted no earlier than that IDLE cycle; there is no back-to-back overlap.

## Timing
- Reset (asynchronous, active-high): state=IDLE, counters=0, sign_mode=0.
  - Outputs during and after reset: in_ready=1, all other outputs 0.
- Deasserting reset has effect at the first clk edge after release.
- Acceptance edge = t0:
  - LOAD is cycle t0+1.
  - PRECOMP is cycles t0+2 .. t0+1+PRE_CYCLES.
  - ITER is the next N_DIGITS cycles.
  - out_valid first goes high at t0+2+PRE_CYCLES+N_DIGITS.
- Minimum latency: 1+PRE_CYCLES+N_DIGITS cycles. For WIDTH=16, PRE_CYCLES=2 this is 7.
- Minimum request period: latency + 2 cycles (one DONE cycle, one IDLE cycle).
- abort sampled high at edge t: IDLE from cycle t+1. Enables are low from that cycle.

## Structure
- mul_pkg holds:
  - WIDTH
  - DIGIT_BITS=4
  - N_DIGITS
  - ctrl_state_t enum {IDLE, LOAD, PRECOMP, ITER, DONE}
- One sub-module, booth16_phase_cnt: a loadable down-counter with a terminal-count flag.
  - The controller reuses it for the PRECOMP and ITER phase lengths.
  - digit_idx is derived from its value.
- The controller is one state register, one booth16_phase_cnt instance and one output decoder.

## Test plan
- Reset mid-ITER (WIDTH=16): assert rst → in_ready=1 and all enables 0 in the same cycle (asynchronous). After release, a request is accepted normally.
- Single request, WIDTH=16, PRE_CYCLES=2, out_ready=1:
  - load pulse at t0+1, precomp_en at t0+2..3, acc_en/shift_en at t0+4..7 with digit_idx 0,1,2,3.
  - out_valid at t0+8 for exactly 1 cycle.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid held, all enables 0. Raising out_ready gives IDLE on the next cycle.
- abort during PRECOMP cycle 2 → IDLE next cycle, no acc_en pulses. A following request with in_signed=1 gives sign_mode=1 and full timing.
- in_valid held high throughout ITER and DONE → no second LOAD. It is accepted only in the IDLE cycle after DONE.
- WIDTH=32, PRE_CYCLES=3 → 8 ITER cycles with digit_idx 0..7, latency 12.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared widths and state encoding for the radix-16 Booth multiplier controller.
package mul_pkg;

    localparam int WIDTH      = 16;
    localparam int DIGIT_BITS = 4;
    localparam int N_DIGITS   = WIDTH / DIGIT_BITS;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRECOMP,
        ITER,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/booth16_phase_cnt.sv
// Loadable down-counter with a terminal-count flag; times the multiplier phases.
module booth16_phase_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/booth16_mul_ctrl.sv
// Sequencing controller for the radix-16 Booth multiplier datapath (timing only, no data).
//
// state   | meaning
// IDLE    | waiting for a request, in_ready high
// LOAD    | operand registers load, accumulator clears
// PRECOMP | hard multiples 3x/5x/7x being generated
// ITER    | one Booth digit accumulated and shifted per cycle
// DONE    | result final, held until out_ready
module booth16_mul_ctrl
    import mul_pkg::*;
#(
    parameter int  WIDTH      = mul_pkg::WIDTH,
    parameter int  PRE_CYCLES = 2,
    localparam int N_DIG      = WIDTH / DIGIT_BITS,
    localparam int IDX_W      = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic             abort,
    output logic             load_mcand,
    output logic             load_mplier,
    output logic             acc_clr,
    output logic             precomp_en,
    output logic             acc_en,
    output logic             shift_en,
    output logic [IDX_W-1:0] digit_idx,
    output logic             sign_mode,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CNT_MAX = (PRE_CYCLES > N_DIG) ? PRE_CYCLES : N_DIG;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(N_DIG - 1);

    ctrl_state_t      state;
    ctrl_state_t      state_nxt;
    logic             cnt_clr;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_tc;
    logic [CNT_W-1:0] digit_full;
    logic             accept;

    // One counter serves both phases; it runs down so the digit index is its complement.
    booth16_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .tc       (cnt_tc)
    );

    assign accept     = (state == IDLE) && in_valid;
    assign digit_full = DIG_LAST - cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_mode <= 1'b0;
        end else if (accept) begin
            sign_mode <= in_signed;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_val   = '0;
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) state_nxt = LOAD;
                end
                LOAD: begin
                    state_nxt = PRECOMP;
                    cnt_load  = 1'b1;
                    cnt_val   = PRE_LAST;
                end
                PRECOMP: begin
                    if (cnt_tc) begin
                        state_nxt = ITER;
                        cnt_load  = 1'b1;
                        cnt_val   = DIG_LAST;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ITER: begin
                    if (cnt_tc) state_nxt = DONE;
                    else        cnt_dec   = 1'b1;
                end
                DONE: begin
                    if (out_ready) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready    = 1'b0;
        load_mcand  = 1'b0;
        load_mplier = 1'b0;
        acc_clr     = 1'b0;
        precomp_en  = 1'b0;
        acc_en      = 1'b0;
        shift_en    = 1'b0;
        out_valid   = 1'b0;
        digit_idx   = '0;
        case (state)
            IDLE:    in_ready = 1'b1;
            LOAD: begin
                load_mcand  = 1'b1;
                load_mplier = 1'b1;
                acc_clr     = 1'b1;
            end
            PRECOMP: precomp_en = 1'b1;
            ITER: begin
                acc_en    = 1'b1;
                shift_en  = 1'b1;
                digit_idx = digit_full[IDX_W-1:0];
            end
            DONE:    out_valid = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_booth16_mul_ctrl.sv
// Drives a 16-bit/2-precompute and a 32-bit/3-precompute controller from one stimulus
// stream and compares both against a timeline model of each request.
module tb_booth16_mul_ctrl;

    logic clk;
    logic rst;
    logic in_valid;
    logic in_signed;
    logic abort;
    logic out_ready;

    logic       in_ready_a, load_mcand_a, load_mplier_a, acc_clr_a, precomp_en_a;
    logic       acc_en_a, shift_en_a, sign_mode_a, out_valid_a;
    logic [1:0] digit_a;
    logic       in_ready_b, load_mcand_b, load_mplier_b, acc_clr_b, precomp_en_b;
    logic       acc_en_b, shift_en_b, sign_mode_b, out_valid_b;
    logic [2:0] digit_b;

    booth16_mul_ctrl #(.WIDTH(16), .PRE_CYCLES(2)) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready_a),
        .in_signed   (in_signed),
        .abort       (abort),
        .load_mcand  (load_mcand_a),
        .load_mplier (load_mplier_a),
        .acc_clr     (acc_clr_a),
        .precomp_en  (precomp_en_a),
        .acc_en      (acc_en_a),
        .shift_en    (shift_en_a),
        .digit_idx   (digit_a),
        .sign_mode   (sign_mode_a),
        .out_valid   (out_valid_a),
        .out_ready   (out_ready)
    );

    booth16_mul_ctrl #(.WIDTH(32), .PRE_CYCLES(3)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready_b),
        .in_signed   (in_signed),
        .abort       (abort),
        .load_mcand  (load_mcand_b),
        .load_mplier (load_mplier_b),
        .acc_clr     (acc_clr_b),
        .precomp_en  (precomp_en_b),
        .acc_en      (acc_en_b),
        .shift_en    (shift_en_b),
        .digit_idx   (digit_b),
        .sign_mode   (sign_mode_b),
        .out_valid   (out_valid_b),
        .out_ready   (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: per request, k = cycles since the acceptance edge (1 = LOAD).
    int pre_c[2] = '{2, 3};
    int nd_c[2]  = '{4, 8};
    bit m_busy[2];
    int m_k[2];
    bit m_sign[2];

    int  ld_cyc[2];
    int  lat[2];
    bit  ov_prev[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [8:0] exp_ctrl(input int d);
        int p;
        int n;
        int k;
        logic [8:0] v;
        p = pre_c[d];
        n = nd_c[d];
        k = m_k[d];
        v = '0;
        if (!m_busy[d])           v[8]   = 1'b1;
        else if (k == 1)          v[7:5] = 3'b111;
        else if (k <= 1 + p)      v[4]   = 1'b1;
        else if (k <= 1 + p + n)  v[3:2] = 2'b11;
        else                      v[1]   = 1'b1;
        v[0] = m_sign[d];
        return v;
    endfunction

    function automatic int exp_digit(input int d);
        int p;
        int n;
        p = pre_c[d];
        n = nd_c[d];
        if (m_busy[d] && m_k[d] >= 2 + p && m_k[d] <= 1 + p + n) return m_k[d] - 2 - p;
        return 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0;
            m_k[d]    = 0;
            m_sign[d] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d] = 1'b0;
                m_k[d]    = 0;
                m_sign[d] = 1'b0;
            end else if (!m_busy[d]) begin
                if (in_valid) begin
                    m_busy[d] = 1'b1;
                    m_k[d]    = 1;
                    m_sign[d] = in_signed;
                end
            end else if (abort) begin
                m_busy[d] = 1'b0;
            end else if (m_k[d] >= 2 + pre_c[d] + nd_c[d]) begin
                if (out_ready) m_busy[d] = 1'b0;
            end else begin
                m_k[d]++;
            end
        end
    endtask

    task automatic check_outputs();
        logic [8:0] obs_a;
        logic [8:0] obs_b;
        obs_a = {in_ready_a, load_mcand_a, load_mplier_a, acc_clr_a, precomp_en_a,
                 acc_en_a, shift_en_a, out_valid_a, sign_mode_a};
        obs_b = {in_ready_b, load_mcand_b, load_mplier_b, acc_clr_b, precomp_en_b,
                 acc_en_b, shift_en_b, out_valid_b, sign_mode_b};
        chk("a_ctrl",  32'(obs_a),   32'(exp_ctrl(0)));
        chk("a_digit", 32'(digit_a), 32'(exp_digit(0)));
        chk("b_ctrl",  32'(obs_b),   32'(exp_ctrl(1)));
        chk("b_digit", 32'(digit_b), 32'(exp_digit(1)));
        if (load_mcand_a) ld_cyc[0] = cyc;
        if (load_mcand_b) ld_cyc[1] = cyc;
        if (out_valid_a && !ov_prev[0]) lat[0] = cyc - ld_cyc[0];
        if (out_valid_b && !ov_prev[1]) lat[1] = cyc - ld_cyc[1];
        ov_prev[0] = out_valid_a;
        ov_prev[1] = out_valid_b;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    // Reset raised between clock edges; outputs must react before the next edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        lat    = '{-1, -1};
        ld_cyc = '{0, 0};
        ov_prev = '{1'b0, 1'b0};
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // single request with a ready consumer; latency counted from LOAD to out_valid
        lat = '{-1, -1};
        in_valid  = 1'b1;
        cycle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (14) cycle();
        chk("lat_a", 32'(lat[0]), 32'd7);
        chk("lat_b", 32'(lat[1]), 32'd12);

        // backpressure in DONE
        in_valid  = 1'b1;
        cycle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (18) cycle();
        out_ready = 1'b1;
        repeat (3) cycle();

        // abort during the second PRECOMP cycle, then a signed request
        in_valid  = 1'b1;
        in_signed = 1'b0;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        abort = 1'b1;
        cycle();
        abort     = 1'b0;
        in_valid  = 1'b1;
        in_signed = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (16) cycle();

        // in_valid held high across whole operations
        in_valid  = 1'b1;
        in_signed = 1'b0;
        repeat (40) cycle();
        in_valid = 1'b0;
        repeat (2) cycle();

        // reset while the 16-bit controller is in ITER, then a normal request
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (4) cycle();
        async_reset();
        lat = '{-1, -1};
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (14) cycle();
        chk("lat_a_post_rst", 32'(lat[0]), 32'd7);
        chk("lat_b_post_rst", 32'(lat[1]), 32'd12);

        // randomized traffic
        repeat (3000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_signed = 1'($urandom_range(0, 1));
            abort     = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 499) == 0) async_reset();
            else cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
